// File: rtl/scc_wave_memory_pkg.sv
// Shared constants and helpers for the SCC wave-table memory.
// Index layout is {id, a}, i.e. id*32 + a.
package scc_wave_memory_pkg;

  localparam int NUM_CH         = 5;
  localparam int DEPTH_W        = 5;
  localparam int WAVE_RAM_DEPTH = NUM_CH * (1 << DEPTH_W);

  localparam logic [2:0] NUM_CH_ID     = 3'(NUM_CH);
  localparam logic [2:0] CH_E          = 3'd4;
  localparam logic [2:0] CH_D          = 3'd3;
  localparam logic [7:0] INVALID_RDATA = 8'hFF;
  localparam logic [7:0] LAST_INDEX    = 8'(WAVE_RAM_DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } wave_state_t;

  function automatic logic [7:0] wave_index(input logic [2:0] id, input logic [4:0] a);
    return {id, a};
  endfunction

  // Plain SCC has only four wave RAMs; channel E shares D's table.
  function automatic logic [2:0] redirect_id(input logic [2:0] id, input logic scci);
    return (!scci && id == CH_E) ? CH_D : id;
  endfunction

endpackage

// File: rtl/scc_wave_ram.sv
// 160x8 single-port synchronous RAM, read-before-write, 1-clk read latency.
module scc_wave_ram
  import scc_wave_memory_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] mem_reg [0:WAVE_RAM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= d;
    end
    q <= mem_reg[addr];
  end

endmodule

// File: rtl/scc_wave_memory.sv
// SCC wave-table responder: arbitrates tone-slot reads, CPU accesses and the
// post-reset clear onto one single-port RAM.
module scc_wave_memory
  import scc_wave_memory_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       enable,
  input  logic [2:0] sram_id,
  input  logic [4:0] sram_a,
  input  logic [7:0] sram_d,
  input  logic       sram_oe,
  input  logic       sram_we,
  output logic [7:0] sram_q,
  output logic       sram_q_en,
  input  logic       reg_scci_enable,
  input  logic [2:0] tone_id,
  input  logic [4:0] tone_a,
  output logic [7:0] tone_q,
  output logic       tone_q_en,
  output logic       init_busy
);

  wave_state_t state_reg;
  logic [7:0]  init_idx_reg;
  logic        req_level, req_level_reg, req_edge;
  logic        pend_reg, pend_we_reg;
  logic [2:0]  pend_id_reg;
  logic [4:0]  pend_a_reg;
  logic [7:0]  pend_d_reg;
  logic        tone_rd_reg, tone_inv_reg, cpu_rd_reg, cpu_inv_reg;

  logic        tone_slot, init_slot, cpu_slot;
  logic [2:0]  tone_id_eff, cpu_id_eff;
  logic        tone_valid, cpu_rd_valid, cpu_wr_ok;
  logic [7:0]  ram_addr, ram_d, ram_q;
  logic        ram_we;

  assign req_level = sram_oe | sram_we;
  assign req_edge  = req_level & ~req_level_reg;

  // Edge-detect history is not reset, so a strobe held across reset is not replayed.
  always_ff @(posedge clk) begin
    req_level_reg <= req_level;
  end

  always_comb begin
    tone_id_eff  = redirect_id(tone_id, reg_scci_enable);
    cpu_id_eff   = redirect_id(pend_id_reg, reg_scci_enable);
    tone_valid   = tone_id_eff < NUM_CH_ID;
    cpu_rd_valid = cpu_id_eff < NUM_CH_ID;
    cpu_wr_ok    = (pend_id_reg < NUM_CH_ID) && (reg_scci_enable || pend_id_reg != CH_E);
    tone_slot    = enable;
    init_slot    = !enable && state_reg == ST_INIT;
    cpu_slot     = !enable && state_reg == ST_RUN && pend_reg;
    ram_addr     = 8'd0;
    ram_we       = 1'b0;
    ram_d        = 8'd0;
    if (tone_slot) begin
      ram_addr = tone_valid ? wave_index(tone_id_eff, tone_a) : 8'd0;
    end else if (init_slot) begin
      ram_addr = init_idx_reg;
      ram_we   = nreset;
    end else if (cpu_slot) begin
      if (pend_we_reg) begin
        ram_addr = cpu_wr_ok ? wave_index(pend_id_reg, pend_a_reg) : 8'd0;
        ram_we   = nreset & cpu_wr_ok;
        ram_d    = pend_d_reg;
      end else begin
        ram_addr = cpu_rd_valid ? wave_index(cpu_id_eff, pend_a_reg) : 8'd0;
      end
    end
  end

  scc_wave_ram u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .d    (ram_d),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_reg    <= ST_INIT;
      init_idx_reg <= 8'd0;
      init_busy    <= 1'b1;
      pend_reg     <= 1'b0;
      pend_we_reg  <= 1'b0;
      pend_id_reg  <= 3'd0;
      pend_a_reg   <= 5'd0;
      pend_d_reg   <= 8'd0;
      tone_rd_reg  <= 1'b0;
      tone_inv_reg <= 1'b0;
      cpu_rd_reg   <= 1'b0;
      cpu_inv_reg  <= 1'b0;
      tone_q       <= 8'd0;
      tone_q_en    <= 1'b0;
      sram_q       <= 8'd0;
      sram_q_en    <= 1'b0;
    end else begin
      if (init_slot) begin
        if (init_idx_reg == LAST_INDEX) begin
          state_reg <= ST_RUN;
          init_busy <= 1'b0;
        end else begin
          init_idx_reg <= init_idx_reg + 8'd1;
        end
      end
      // A fresh edge wins over the service of the older request.
      if (req_edge) begin
        pend_reg    <= 1'b1;
        pend_we_reg <= sram_we;
        pend_id_reg <= sram_id;
        pend_a_reg  <= sram_a;
        pend_d_reg  <= sram_d;
      end else if (cpu_slot) begin
        pend_reg <= 1'b0;
      end
      tone_rd_reg  <= tone_slot;
      tone_inv_reg <= !tone_valid;
      cpu_rd_reg   <= cpu_slot && !pend_we_reg;
      cpu_inv_reg  <= !cpu_rd_valid;
      tone_q_en    <= tone_rd_reg;
      if (tone_rd_reg) begin
        tone_q <= tone_inv_reg ? INVALID_RDATA : ram_q;
      end
      sram_q_en <= cpu_rd_reg;
      if (cpu_rd_reg) begin
        sram_q <= cpu_inv_reg ? INVALID_RDATA : ram_q;
      end
    end
  end

endmodule

// File: tb/tb_scc_wave_memory.sv
// Directed testbench for scc_wave_memory; each task checks its own scenario.
module tb_scc_wave_memory;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] sram_id = 3'd0;
  logic [4:0] sram_a = 5'd0;
  logic [7:0] sram_d = 8'd0;
  logic       sram_oe = 1'b0;
  logic       sram_we = 1'b0;
  logic [7:0] sram_q;
  logic       sram_q_en;
  logic       reg_scci_enable = 1'b1;
  logic [2:0] tone_id = 3'd0;
  logic [4:0] tone_a = 5'd0;
  logic [7:0] tone_q;
  logic       tone_q_en;
  logic       init_busy;

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_mem [0:159];

  scc_wave_memory dut (
    .clk             (clk),
    .nreset          (nreset),
    .enable          (enable),
    .sram_id         (sram_id),
    .sram_a          (sram_a),
    .sram_d          (sram_d),
    .sram_oe         (sram_oe),
    .sram_we         (sram_we),
    .sram_q          (sram_q),
    .sram_q_en       (sram_q_en),
    .reg_scci_enable (reg_scci_enable),
    .tone_id         (tone_id),
    .tone_a          (tone_a),
    .tone_q          (tone_q),
    .tone_q_en       (tone_q_en),
    .init_busy       (init_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts non-enable clocks from reset release until init_busy drops.
  task automatic run_init(input int period, output int cnt);
    logic was_en;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      enable = (period != 0) && (i % period == period - 1);
      was_en = enable;
      step();
      if (!was_en) cnt++;
      if (!init_busy) break;
    end
    enable = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] id, input logic [4:0] a, input logic [7:0] d,
                           output logic saw_en);
    sram_id = id; sram_a = a; sram_d = d; sram_we = 1'b1;
    step();
    saw_en = sram_q_en;
    sram_we = 1'b0;
    step();
    saw_en |= sram_q_en;
    step();
    saw_en |= sram_q_en;
    $display("write id=%0d a=%02h d=%02h", id, a, d);
  endtask

  // Returns q_en one clk after capture+1 (early) and two clks after (on time).
  task automatic cpu_read(input logic [2:0] id, input logic [4:0] a,
                          output logic early_en, output logic en, output logic [7:0] q);
    sram_id = id; sram_a = a; sram_oe = 1'b1;
    step();
    step();
    early_en = sram_q_en;
    sram_oe = 1'b0;
    step();
    en = sram_q_en;
    q = sram_q;
    $display("read  id=%0d a=%02h -> q=%02h en=%0b", id, a, q, en);
  endtask

  task automatic tone_read(input logic [2:0] id, input logic [4:0] a,
                           output logic en, output logic [7:0] q);
    tone_id = id; tone_a = a; enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    en = tone_q_en;
    q = tone_q;
    $display("tone  id=%0d a=%02h -> q=%02h en=%0b", id, a, q, en);
  endtask

  task automatic test_reset();
    int cnt;
    logic e0, e1;
    logic [7:0] q;
    nreset = 1'b0;
    repeat (3) step();
    checks++; if (sram_q !== 8'h00) $display("FAIL reset_sram_q got=%02h exp=00", sram_q); else passes++;
    checks++; if (sram_q_en !== 1'b0) $display("FAIL reset_sram_q_en got=%0b exp=0", sram_q_en); else passes++;
    checks++; if (tone_q !== 8'h00) $display("FAIL reset_tone_q got=%02h exp=00", tone_q); else passes++;
    checks++; if (tone_q_en !== 1'b0) $display("FAIL reset_tone_q_en got=%0b exp=0", tone_q_en); else passes++;
    checks++; if (init_busy !== 1'b1) $display("FAIL reset_init_busy got=%0b exp=1", init_busy); else passes++;
    nreset = 1'b1;
    run_init(4, cnt);
    $display("init done after %0d non-enable clks", cnt);
    checks++; if (cnt != 160) $display("FAIL init_len got=%0d exp=160", cnt); else passes++;
    repeat (40) step();
    cpu_read(3'd2, 5'd7, e0, e1, q);
    checks++; if (e0 !== 1'b0 || e1 !== 1'b1) $display("FAIL init_read_en got=%0b%0b exp=01", e0, e1); else passes++;
    checks++; if (q !== 8'h00) $display("FAIL init_read_q got=%02h exp=00", q); else passes++;
    step();
    checks++; if (sram_q_en !== 1'b0) $display("FAIL init_read_pulse got=%0b exp=0", sram_q_en); else passes++;
    for (int i = 0; i < 160; i++) exp_mem[i] = 8'h00;
  endtask

  task automatic test_scci_rw();
    logic w_en, e0, e1;
    logic [7:0] q;
    reg_scci_enable = 1'b1;
    cpu_write(3'd0, 5'd5, 8'h5A, w_en);
    exp_mem[5] = 8'h5A;
    checks++; if (w_en !== 1'b0) $display("FAIL write_no_q_en got=%0b exp=0", w_en); else passes++;
    cpu_read(3'd0, 5'd5, e0, e1, q);
    checks++; if (e0 !== 1'b0 || e1 !== 1'b1) $display("FAIL rd_latency got=%0b%0b exp=01", e0, e1); else passes++;
    checks++; if (q !== 8'h5A) $display("FAIL rd_data got=%02h exp=5A", q); else passes++;
  endtask

  task automatic test_scc_mode();
    logic w_en, e0, e1, en;
    logic [7:0] q;
    reg_scci_enable = 1'b0;
    cpu_write(3'd3, 5'h1F, 8'h81, w_en);
    exp_mem[8'd127] = 8'h81;
    tone_read(3'd4, 5'h1F, en, q);
    checks++; if (en !== 1'b1 || q !== 8'h81) $display("FAIL scc_tone_alias got=%02h/%0b exp=81/1", q, en); else passes++;
    cpu_write(3'd4, 5'h1F, 8'h42, w_en);
    tone_read(3'd3, 5'h1F, en, q);
    checks++; if (q !== 8'h81) $display("FAIL scc_e_write_ignored got=%02h exp=81", q); else passes++;
    cpu_read(3'd4, 5'h1F, e0, e1, q);
    checks++; if (e1 !== 1'b1 || q !== 8'h81) $display("FAIL scc_cpu_alias got=%02h/%0b exp=81/1", q, e1); else passes++;
    reg_scci_enable = 1'b1;
  endtask

  task automatic test_collision();
    // Read edge coincides with an enable: tone first, CPU one clk later.
    sram_id = 3'd0; sram_a = 5'd5; sram_oe = 1'b1;
    tone_id = 3'd0; tone_a = 5'd5; enable = 1'b1;
    step();
    enable = 1'b0;
    sram_oe = 1'b0;
    step();
    checks++; if (tone_q_en !== 1'b1 || tone_q !== 8'h5A) $display("FAIL coll_tone got=%02h/%0b exp=5A/1", tone_q, tone_q_en); else passes++;
    checks++; if (sram_q_en !== 1'b0) $display("FAIL coll_cpu_early got=%0b exp=0", sram_q_en); else passes++;
    step();
    checks++; if (sram_q_en !== 1'b1 || sram_q !== 8'h5A) $display("FAIL coll_cpu got=%02h/%0b exp=5A/1", sram_q, sram_q_en); else passes++;
    $display("collision: tone then cpu read of 5A");
    // Enable on the service clk: the CPU access slips one clk.
    sram_id = 3'd3; sram_a = 5'h1F; sram_oe = 1'b1;
    step();
    sram_oe = 1'b0;
    tone_id = 3'd0; tone_a = 5'd0; enable = 1'b1;
    step();
    enable = 1'b0;
    step();
    checks++; if (sram_q_en !== 1'b0) $display("FAIL slip_early got=%0b exp=0", sram_q_en); else passes++;
    step();
    checks++; if (sram_q_en !== 1'b1 || sram_q !== 8'h81) $display("FAIL slip_cpu got=%02h/%0b exp=81/1", sram_q, sram_q_en); else passes++;
    $display("slip: cpu read of 81 delayed by enable");
  endtask

  task automatic test_invalid_ids();
    logic w_en, e0, e1;
    logic [7:0] q;
    cpu_read(3'd6, 5'd3, e0, e1, q);
    checks++; if (e1 !== 1'b1) $display("FAIL inv_read_en got=%0b exp=1", e1); else passes++;
    checks++; if (q !== 8'hFF) $display("FAIL inv_read_q got=%02h exp=FF", q); else passes++;
    cpu_write(3'd7, 5'd2, 8'hAA, w_en);
    for (int i = 0; i < 160; i++) begin
      cpu_read(3'(i / 32), 5'(i % 32), e0, e1, q);
      checks++;
      if (e1 !== 1'b1 || q !== exp_mem[i])
        $display("FAIL dump[%0d] got=%02h/%0b exp=%02h/1", i, q, e1, exp_mem[i]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_init();
    int cnt;
    logic e0, e1;
    logic [7:0] q;
    nreset = 1'b0;
    repeat (2) step();
    nreset = 1'b1;
    repeat (80) step();
    sram_id = 3'd1; sram_a = 5'd3; sram_d = 8'h77; sram_we = 1'b1;
    step();
    sram_we = 1'b0;
    step();
    nreset = 1'b0;
    repeat (2) step();
    nreset = 1'b1;
    run_init(0, cnt);
    $display("re-init done after %0d clks", cnt);
    checks++; if (cnt != 160) $display("FAIL reinit_len got=%0d exp=160", cnt); else passes++;
    step();
    cpu_read(3'd1, 5'd3, e0, e1, q);
    checks++; if (e1 !== 1'b1 || q !== 8'h00) $display("FAIL pend_dropped got=%02h/%0b exp=00/1", q, e1); else passes++;
  endtask

  initial begin
    test_reset();
    test_scci_rw();
    test_scc_mode();
    test_collision();
    test_invalid_ids();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
